// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction layout, FSM states.
package alu_seq_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 6;
    localparam int RD_HI   = 5;
    localparam int RD_LO   = 4;
    localparam int RS_HI   = 3;
    localparam int RS_LO   = 2;
    localparam int RT_HI   = 1;
    localparam int RT_LO   = 0;

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Field order matches the OP/RD/RS/RT slice positions above.
    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
    } instr_t;

endpackage

// File: rtl/Decode_And_Execute.sv
// Combinational 4-bit ALU: decodes a 3-bit select and computes the result of rs/rt.
module Decode_And_Execute
    import alu_seq_pkg::*;
(
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    input  logic [2:0] sel,
    output logic [3:0] out
);

    always_comb begin
        // NOTE: out gets a default before the case so no path can infer a latch.
        out = 4'd0;
        case (sel)
            OP_SUB:  out = rs - rt;
            OP_ADD:  out = rs + rt;
            OP_OR:   out = rs | rt;
            OP_AND:  out = rs & rt;
            OP_SRA:  out = {rt[3], rt[3:1]};
            OP_ROL:  out = {rs[2:0], rs[3]};
            OP_LT:   out = {3'b101, rs < rt};
            OP_EQ:   out = {3'b111, rs == rt};
            default: out = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Streams queued instructions through Decode_And_Execute, one every two cycles.
// Optional instr_count statistic is enabled by defining SEQ_STATS_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               ld_en,
    input  logic [1:0]         ld_addr,
    input  logic [3:0]         ld_data,
    output logic               ld_ready,
    input  logic [1:0]         rd_addr,
    output logic [3:0]         rd_data,
    output logic               res_valid,
    output logic [1:0]         res_rd,
    output logic [3:0]         res_data,
    output logic               busy,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    instr_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ld_fire;

    state_t           state;
    instr_t           ir;
    logic [3:0]       regs [4];
    logic [3:0]       alu_out;

    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = ((state == IDLE) || (state == WB)) && !empty;
    assign ld_ready = (state == IDLE) && empty;
    assign ld_fire  = ld_en && ld_ready;
    assign busy     = (state != IDLE) || !empty;
    assign rd_data  = regs[rd_addr];

    // NOTE: queue storage has no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr_t'(in_instr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample together.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    Decode_And_Execute u_alu (
        .rs  (regs[ir.rs]),
        .rt  (regs[ir.rt]),
        .sel (ir.op),
        .out (alu_out)
    );

    // Loads only fire in IDLE with an empty queue, so they never collide with writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
        end else if (state == EXEC) begin
            regs[ir.rd] <= alu_out;
        end else if (ld_fire) begin
            regs[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ir        <= '0;
            res_valid <= 1'b0;
            res_rd    <= 2'd0;
            res_data  <= 4'd0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        ir    <= fifo_mem[rd_ptr];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    res_rd    <= ir.rd;
                    res_data  <= alu_out;
                    state     <= WB;
                end
                WB: begin
                    if (!empty) begin
                        ir    <= fifo_mem[rd_ptr];
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_STATS_EN
    logic [CNT_W-1:0] exec_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt <= '0;
        end else if ((state == EXEC) && (exec_cnt != '1)) begin
            exec_cnt <= exec_cnt + CNT_W'(1);
        end
    end

    assign instr_count = exec_cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_instr;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic       ld_ready;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       res_valid;
    logic [1:0] res_rd;
    logic [3:0] res_data;
    logic       busy;
    logic [7:0] instr_count;

    int errors = 0;
    int checks = 0;

    logic [8:0] bp      [8];
    logic [3:0] bp_exp  [7] = '{4'h8, 4'h2, 4'h7, 4'h1, 4'hE, 4'hA, 4'hF};
    logic [1:0] bp_rd   [7] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    logic [3:0] chain_exp [4] = '{4'd2, 4'd4, 4'd8, 4'd0};

    alu_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .res_valid   (res_valid),
        .res_rd      (res_rd),
        .res_data    (res_data),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [3:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    // Issue one instruction from IDLE and check the exact E2 result timing.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] exp);
        in_instr = mk(op, rd, rs, rt);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_e0_novalid"}, res_valid, 1'b0);
        tick();
        check({tag, "_e1_novalid"}, res_valid, 1'b0);
        tick();
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_rd"}, res_rd, rd);
        check({tag, "_data"}, res_data, exp);
        tick();
        check({tag, "_e3_novalid"}, res_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        rd_addr  = '0;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        check("por_in_ready", in_ready, 1'b1);
        check("por_ld_ready", ld_ready, 1'b1);
        check("por_busy", busy, 1'b0);
        check("por_res_valid", res_valid, 1'b0);
        check("por_res_data", res_data, 4'd0);
        check("por_instr_count", instr_count, 8'd0);
        check("por_rd_data", rd_data, 4'd0);
        tick();
        rst = 1'b0;
        tick();

        // Subtract with exact latency
        load(2'd0, 4'd8);
        load(2'd1, 4'd3);
        do_op("sub", OP_SUB, 2'd2, 2'd0, 2'd1, 4'd5);
        check_reg("sub_r2", 2'd2, 4'd5);
        check("sub_idle_busy", busy, 1'b0);

        // Wrap and compares
        load(2'd1, 4'd8);
        do_op("add_wrap", OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0);
        load(2'd0, 4'd3);
        load(2'd1, 4'd5);
        do_op("lt", OP_LT, 2'd2, 2'd0, 2'd1, 4'b1011);
        do_op("eq_same", OP_EQ, 2'd3, 2'd0, 2'd0, 4'b1111);
        do_op("eq_diff", OP_EQ, 2'd3, 2'd0, 2'd1, 4'b1110);

        // Shifts
        load(2'd1, 4'b1000);
        do_op("sra", OP_SRA, 2'd2, 2'd0, 2'd1, 4'b1100);
        load(2'd0, 4'b1001);
        do_op("rol", OP_ROL, 2'd3, 2'd0, 2'd0, 4'b0011);

        // Load and enqueue in the same IDLE cycle: load must be seen by the op
        ld_en    = 1'b1;
        ld_addr  = 2'd0;
        ld_data  = 4'd6;
        in_instr = mk(OP_ADD, 2'd2, 2'd0, 2'd0);
        in_valid = 1'b1;
        tick();
        ld_en    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("ldq_valid", res_valid, 1'b1);
        check("ldq_data", res_data, 4'd12);
        tick();

        // Backpressure: 4-deep queue fills after the seventh back-to-back push
        load(2'd0, 4'd3);
        load(2'd1, 4'd5);
        bp[0] = mk(OP_ADD, 2'd2, 2'd0, 2'd1);
        bp[1] = mk(OP_SUB, 2'd3, 2'd1, 2'd0);
        bp[2] = mk(OP_OR,  2'd2, 2'd0, 2'd1);
        bp[3] = mk(OP_AND, 2'd3, 2'd0, 2'd1);
        bp[4] = mk(OP_SUB, 2'd2, 2'd0, 2'd1);
        bp[5] = mk(OP_LT,  2'd3, 2'd1, 2'd0);
        bp[6] = mk(OP_EQ,  2'd2, 2'd1, 2'd1);
        bp[7] = mk(OP_ADD, 2'd3, 2'd0, 2'd0);
        for (int cyc = 0; cyc < 18; cyc++) begin
            in_valid = (cyc < 8);
            if (cyc < 8) in_instr = bp[cyc];
            ld_en   = (cyc == 9);
            ld_addr = 2'd0;
            ld_data = 4'd9;
            if (cyc == 7) check("bp_full_in_ready", in_ready, 1'b0);
            if (cyc == 9) check("bp_busy_ld_ready", ld_ready, 1'b0);
            tick();
            if (cyc == 7) check("bp_after_pop_in_ready", in_ready, 1'b1);
            if (cyc >= 2 && cyc <= 14 && (cyc % 2) == 0) begin
                check($sformatf("bp_valid_%0d", cyc), res_valid, 1'b1);
                check($sformatf("bp_rd_%0d", cyc), res_rd, bp_rd[cyc/2-1]);
                check($sformatf("bp_data_%0d", cyc), res_data, bp_exp[cyc/2-1]);
            end else begin
                check($sformatf("bp_novalid_%0d", cyc), res_valid, 1'b0);
            end
        end
        in_valid = 1'b0;
        ld_en    = 1'b0;
        check("bp_done_busy", busy, 1'b0);
        check_reg("bp_ld_dropped_r0", 2'd0, 4'd3);

        // Reset mid-run with instructions queued
        in_instr = mk(OP_ADD, 2'd3, 2'd0, 2'd1);
        in_valid = 1'b1;
        tick();
        in_instr = mk(OP_SUB, 2'd2, 2'd0, 2'd1);
        tick();
        in_instr = mk(OP_OR, 2'd1, 2'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            check($sformatf("rst_no_result_%0d", cyc), res_valid, 1'b0);
        end
        check_reg("rst_r0", 2'd0, 4'd0);
        check_reg("rst_r1", 2'd1, 4'd0);
        check_reg("rst_r2", 2'd2, 4'd0);
        check_reg("rst_r3", 2'd3, 4'd0);
        check("rst_instr_count", instr_count, 8'd0);
        tick();

        // Dependency chain r0 = r0 + r0, four times
        load(2'd0, 4'd1);
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (cyc < 4);
            in_instr = mk(OP_ADD, 2'd0, 2'd0, 2'd0);
            tick();
            if (cyc >= 2 && cyc <= 8 && (cyc % 2) == 0) begin
                check($sformatf("chain_valid_%0d", cyc), res_valid, 1'b1);
                check($sformatf("chain_data_%0d", cyc), res_data, chain_exp[cyc/2-1]);
            end else begin
                check($sformatf("chain_novalid_%0d", cyc), res_valid, 1'b0);
            end
        end
        in_valid = 1'b0;
        check_reg("chain_r0", 2'd0, 4'd0);
`ifdef SEQ_STATS_EN
        check("chain_instr_count", instr_count, 8'd4);
`else
        check("chain_instr_count", instr_count, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
